// File: rtl/handshake_channel_monitor_pkg.sv
// Shared types and default parameters for the handshake channel monitor.
// The optional HSMON_ASSERT_EN build adds per-channel SVA checks in the top.
package hsmon_pkg;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_VALID_DROP  = 2'd1,
    ERR_DATA_CHANGE = 2'd2,
    ERR_STALL       = 2'd3
  } err_e;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_e;

  localparam int unsigned HSMON_N_CH      = 4;
  localparam int unsigned HSMON_DATA_W    = 4;
  localparam int unsigned HSMON_STALL_MAX = 16;
  localparam int unsigned HSMON_CNT_W     = 8;

endpackage

// File: rtl/handshake_channel_monitor_if.sv
// Bundle of N ready/valid channels; the monitor attaches through the passive mon modport.
interface handshake_channel_monitor_if
  import hsmon_pkg::*;
#(
  parameter int unsigned N_CH   = HSMON_N_CH,
  parameter int unsigned DATA_W = HSMON_DATA_W
);
  logic [N_CH-1:0]        valid;
  logic [N_CH-1:0]        ready;
  logic [N_CH*DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
  modport mon    (input valid, input ready, input data);
endinterface

// File: rtl/handshake_channel_monitor_hs_chan_checker.sv
// One channel of the monitor: FSM, payload capture, stall counter,
// saturating transfer counter and first-error recording.
module hs_chan_checker
  import hsmon_pkg::*;
#(
  parameter int unsigned DATA_W    = HSMON_DATA_W,
  parameter int unsigned STALL_MAX = HSMON_STALL_MAX,
  parameter int unsigned CNT_W     = HSMON_CNT_W
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              clear,
  input  logic              valid,
  input  logic              ready,
  input  logic [DATA_W-1:0] data,
  output logic              pending,
  output logic              err_sticky,
  output err_e              err_code,
  output logic [CNT_W-1:0]  txn_count
);
  localparam int unsigned SW = $clog2(STALL_MAX + 1);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  cap_q, cap_d;
  logic [SW-1:0]      stall_q, stall_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sticky_q, sticky_d;
  err_e               code_q, code_d, code_new;
  logic               fire, pend, viol_drop, viol_chg, viol_stall, viol_any;

  always_comb begin
    fire       = valid && ready;
    pend       = (state_q == PENDING);
    viol_drop  = pend && !valid;
    viol_chg   = pend && valid && (data != cap_q);
    // Timeout fires only on the transition into STALL_MAX; saturation prevents re-flagging.
    viol_stall = pend && valid && !ready && (stall_q == SW'(STALL_MAX - 1));
    viol_any   = viol_drop || viol_chg || viol_stall;

    if (viol_drop)     code_new = ERR_VALID_DROP;
    else if (viol_chg) code_new = ERR_DATA_CHANGE;
    else               code_new = ERR_STALL;

    state_d = state_q;
    cap_d   = cap_q;
    stall_d = stall_q;
    case (state_q)
      IDLE: begin
        if (valid && !ready) begin
          state_d = PENDING;
          cap_d   = data;
          stall_d = SW'(1);
        end
      end
      PENDING: begin
        if (!valid || ready) begin
          state_d = IDLE;
          stall_d = '0;
        end else if (stall_q != SW'(STALL_MAX)) begin
          stall_d = stall_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      cnt_d    = fire ? CNT_W'(1) : '0;
      sticky_d = viol_any;
      code_d   = viol_any ? code_new : ERR_NONE;
    end else begin
      cnt_d    = (fire && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
      sticky_d = sticky_q || viol_any;
      code_d   = (!sticky_q && viol_any) ? code_new : code_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q  <= IDLE;
      cap_q    <= '0;
      stall_q  <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      cap_q    <= cap_d;
      stall_q  <= stall_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      code_q   <= code_d;
    end
  end

  assign pending    = pend;
  assign err_sticky = sticky_q;
  assign err_code   = code_q;
  assign txn_count  = cnt_q;
endmodule

// File: rtl/handshake_channel_monitor.sv
// Passive monitor over N ready/valid channels; one hs_chan_checker per channel.
// Define HSMON_ASSERT_EN to add SVA checks per error class per channel.
module handshake_channel_monitor
  import hsmon_pkg::*;
#(
  parameter int unsigned N_CH      = HSMON_N_CH,
  parameter int unsigned DATA_W    = HSMON_DATA_W,
  parameter int unsigned STALL_MAX = HSMON_STALL_MAX,
  parameter int unsigned CNT_W     = HSMON_CNT_W
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  handshake_channel_monitor_if.mon hs,
  input  logic                    clear,
  output logic [N_CH-1:0]         err_sticky,
  output logic [N_CH*2-1:0]       err_code,
  output logic [N_CH*CNT_W-1:0]   txn_count,
  output logic                    busy
);
  logic [N_CH-1:0] pend;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    hs_chan_checker #(
      .DATA_W    (DATA_W),
      .STALL_MAX (STALL_MAX),
      .CNT_W     (CNT_W)
    ) u_chk (
      .CLK        (CLK),
      .RESETN     (RESETN),
      .clear      (clear),
      .valid      (hs.valid[i]),
      .ready      (hs.ready[i]),
      .data       (hs.data[i*DATA_W +: DATA_W]),
      .pending    (pend[i]),
      .err_sticky (err_sticky[i]),
      .err_code   (err_code[2*i +: 2]),
      .txn_count  (txn_count[i*CNT_W +: CNT_W])
    );

`ifdef HSMON_ASSERT_EN
    a_valid_drop: assert property (@(posedge CLK) disable iff (!RESETN) !u_chk.viol_drop)
      else $error("hsmon: channel %0d VALID_DROP", i);
    a_data_change: assert property (@(posedge CLK) disable iff (!RESETN) !u_chk.viol_chg)
      else $error("hsmon: channel %0d DATA_CHANGE", i);
    a_stall: assert property (@(posedge CLK) disable iff (!RESETN) !u_chk.viol_stall)
      else $error("hsmon: channel %0d STALL_TIMEOUT", i);
`endif
  end

  assign busy = |pend;
endmodule

// File: tb/tb_handshake_channel_monitor.sv
// Directed bench for handshake_channel_monitor: default 4-channel instance plus
// a 1-channel CNT_W=3 instance for counter saturation.
module tb_handshake_channel_monitor;
  logic        CLK = 1'b0;
  logic        RESETN;
  logic        clear;
  logic [3:0]  err_sticky;
  logic [7:0]  err_code;
  logic [31:0] txn_count;
  logic        busy;
  logic        s_err_sticky;
  logic [1:0]  s_err_code;
  logic [2:0]  s_txn_count;
  logic        s_busy;
  int          errors = 0;
  int          checks = 0;

  handshake_channel_monitor_if #(.N_CH(4), .DATA_W(4)) hs ();
  handshake_channel_monitor_if #(.N_CH(1), .DATA_W(4)) hs1 ();

  handshake_channel_monitor #(.N_CH(4), .DATA_W(4), .STALL_MAX(16), .CNT_W(8)) dut (
    .CLK(CLK), .RESETN(RESETN), .hs(hs), .clear(clear),
    .err_sticky(err_sticky), .err_code(err_code), .txn_count(txn_count), .busy(busy)
  );

  handshake_channel_monitor #(.N_CH(1), .DATA_W(4), .STALL_MAX(16), .CNT_W(3)) dut_sat (
    .CLK(CLK), .RESETN(RESETN), .hs(hs1), .clear(clear),
    .err_sticky(s_err_sticky), .err_code(s_err_code), .txn_count(s_txn_count), .busy(s_busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    hs.valid = '0; hs.ready = '0; hs.data = '0;
    hs1.valid = '0; hs1.ready = '0; hs1.data = '0;
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    clear  = 1'b0;
    repeat (2) begin
      hs.valid  = 4'($urandom);
      hs.ready  = 4'($urandom);
      hs.data   = 16'($urandom);
      hs1.valid = 1'($urandom);
      hs1.ready = 1'($urandom);
      hs1.data  = 4'($urandom);
      tick();
    end
    checks++; if (err_sticky !== 4'h0) begin errors++; $display("FAIL reset_sticky got=%h exp=0", err_sticky); end
    checks++; if (err_code !== 8'h00) begin errors++; $display("FAIL reset_code got=%h exp=0", err_code); end
    checks++; if (txn_count !== 32'h0) begin errors++; $display("FAIL reset_count got=%h exp=0", txn_count); end
    checks++; if (busy !== 1'b0 || s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b/%b exp=0", busy, s_busy); end
    checks++; if (s_txn_count !== 3'd0 || s_err_sticky !== 1'b0) begin errors++; $display("FAIL reset_sat got=%0d/%b exp=0/0", s_txn_count, s_err_sticky); end
    idle_inputs();
    RESETN = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    hs.valid[0] = 1'b1; hs.ready[0] = 1'b1; hs.data[3:0] = 4'h9;
    repeat (5) begin
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got=%b exp=0", busy); end
    end
    checks++; if (txn_count[7:0] !== 8'd5) begin errors++; $display("FAIL b2b_count got=%0d exp=5", txn_count[7:0]); end
    checks++; if (err_sticky !== 4'h0) begin errors++; $display("FAIL b2b_sticky got=%h exp=0", err_sticky); end
    hs.valid[0] = 1'b0; hs.ready[0] = 1'b0;
    hs1.valid = 1'b1; hs1.ready = 1'b1; hs1.data = 4'h2;
    repeat (7) tick();
    checks++; if (s_txn_count !== 3'd7) begin errors++; $display("FAIL sat_reach got=%0d exp=7", s_txn_count); end
    repeat (2) tick();
    checks++; if (s_txn_count !== 3'd7) begin errors++; $display("FAIL sat_hold got=%0d exp=7", s_txn_count); end
    checks++; if (s_err_sticky !== 1'b0) begin errors++; $display("FAIL sat_sticky got=%b exp=0", s_err_sticky); end
    hs1.valid = 1'b0; hs1.ready = 1'b0;
    tick();
  endtask

  task automatic test_valid_drop();
    hs.valid[1] = 1'b1; hs.ready[1] = 1'b0; hs.data[7:4] = 4'hA;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy got=%b exp=1", busy); end
    tick();
    checks++; if (err_sticky[1] !== 1'b0) begin errors++; $display("FAIL drop_early got=%b exp=0", err_sticky[1]); end
    hs.valid[1] = 1'b0;
    tick();
    checks++; if (err_sticky[1] !== 1'b1) begin errors++; $display("FAIL drop_sticky got=%b exp=1", err_sticky[1]); end
    checks++; if (err_code[3:2] !== 2'd1) begin errors++; $display("FAIL drop_code got=%0d exp=1", err_code[3:2]); end
    checks++; if (busy !== 1'b0 || txn_count[15:8] !== 8'd0) begin errors++; $display("FAIL drop_idle got=%b/%0d exp=0/0", busy, txn_count[15:8]); end
  endtask

  task automatic test_data_change();
    hs.valid[2] = 1'b1; hs.ready[2] = 1'b0; hs.data[11:8] = 4'h3;
    tick();
    checks++; if (err_sticky[2] !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL chg_pend got=%b/%b exp=0/1", err_sticky[2], busy); end
    hs.data[11:8] = 4'h5;
    tick();
    checks++; if (err_sticky[2] !== 1'b1) begin errors++; $display("FAIL chg_sticky got=%b exp=1", err_sticky[2]); end
    checks++; if (err_code[5:4] !== 2'd2) begin errors++; $display("FAIL chg_code got=%0d exp=2", err_code[5:4]); end
    repeat (20) tick();
    checks++; if (err_code[5:4] !== 2'd2) begin errors++; $display("FAIL chg_first_wins got=%0d exp=2", err_code[5:4]); end
    hs.ready[2] = 1'b1;
    tick();
    checks++; if (txn_count[23:16] !== 8'd1 || busy !== 1'b0) begin errors++; $display("FAIL chg_xfer got=%0d/%b exp=1/0", txn_count[23:16], busy); end
    hs.valid[2] = 1'b0; hs.ready[2] = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    hs.valid[3] = 1'b1; hs.ready[3] = 1'b0; hs.data[15:12] = 4'h7;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy k=%0d got=%b exp=1", k, busy); end
      if (k < 16) begin
        checks++; if (err_sticky[3] !== 1'b0) begin errors++; $display("FAIL stall_early k=%0d got=%b exp=0", k, err_sticky[3]); end
      end
    end
    checks++; if (err_sticky[3] !== 1'b1) begin errors++; $display("FAIL stall_sticky got=%b exp=1", err_sticky[3]); end
    checks++; if (err_code[7:6] !== 2'd3) begin errors++; $display("FAIL stall_code got=%0d exp=3", err_code[7:6]); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (err_sticky !== 4'h0 || err_code !== 8'h00) begin errors++; $display("FAIL clear_errs got=%h/%h exp=0/0", err_sticky, err_code); end
    repeat (3) tick();
    checks++; if (err_sticky[3] !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL stall_noreflag got=%b/%b exp=0/1", err_sticky[3], busy); end
    hs.ready[3] = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (txn_count !== 32'h0100_0000) begin errors++; $display("FAIL clear_xfer got=%h exp=01000000", txn_count); end
    checks++; if (busy !== 1'b0 || err_sticky !== 4'h0) begin errors++; $display("FAIL clear_state got=%b/%h exp=0/0", busy, err_sticky); end
    hs.valid[3] = 1'b0; hs.ready[3] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    hs.valid = 4'hF; hs.ready = 4'h0; hs.data = 16'h1234;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_pend got=%b exp=1", busy); end
    RESETN = 1'b0;
    hs.valid = 4'h0;
    tick();
    RESETN = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if (err_sticky !== 4'h0 || err_code !== 8'h00) begin errors++; $display("FAIL rmid_errs got=%h/%h exp=0/0", err_sticky, err_code); end
    checks++; if (txn_count !== 32'h0) begin errors++; $display("FAIL rmid_count got=%h exp=0", txn_count); end
  endtask

  initial begin
    RESETN = 1'b0;
    clear  = 1'b0;
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_valid_drop();
    test_data_change();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
